mem_port_ctrl: RTL and testbench

Memory port controller between the multi-cycle control FSM and the single shared instruction/data memory. It converts the FSM's per-state memory strobes into a registered req/ack transaction with a variable-latency memory, and stalls the FSM while the transaction is outstanding. It also owns the instruction register (IR) and the memory data register (MDR). The FSM holds its current state and outputs whenever `stall` is high.

---
 rtl/mips_mem_pkg.sv | 7 +
 rtl/mem_port_ctrl_timeout.sv | 20 ++
 rtl/mem_port_ctrl.sv | 90 +++++++++
 tb/tb_mem_port_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding and default sizes for the memory port controller
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_port_ctrl_timeout.sv
// mem_timeout_ctr: counts BUSY cycles without ack and flags expiry on the TIMEOUT-th one
// Ports: clk, rst (sync, active-high), busy (controller in BUSY), ack (memory ack),
//        expired (this BUSY cycle reaches TIMEOUT without ack; ack wins on a tie)
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = busy && !ack && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || !busy) cnt <= '0;
    else if (!ack) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: registered req/ack memory port with FSM stall, IR and MDR
// Ports: clk, in_reset (sync, active-high); FSM side mem_read, mem_write, iord, ir_write,
//        pc, alu_out, wdata, stall; memory side m_req, m_we, m_addr, m_wdata, m_ack, m_rdata;
//        instr (IR), mdr (MDR), bus_err (sticky timeout).
// Optional: define MEM_TIMEOUT_EN to build the BUSY timeout; otherwise bus_err is 0.
module mem_port_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              in_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              iord,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err
);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end
  mem_state_t state, state_nx;
  logic dest, start, done_ok, expired;
  assign start = state == IDLE && (mem_read || mem_write);
  assign done_ok = state == BUSY && m_ack;
  assign stall = !in_reset && (start || state == BUSY);
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(in_reset),
    .busy(state == BUSY),
    .ack(m_ack),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_comb begin
    state_nx = state == IDLE ? (start ? BUSY : IDLE) :
               state == BUSY ? ((done_ok || expired) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      dest    <= 1'b0;
      instr   <= '0;
      mdr     <= '0;
`ifdef MEM_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (start) begin
        m_req   <= 1'b1;
        m_we    <= mem_write;
        m_addr  <= iord ? alu_out : pc;
        m_wdata <= wdata;
        dest    <= ir_write;
      end
      if (done_ok || expired) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
      end
      if (done_ok && !m_we && dest) instr <= m_rdata;
      if (done_ok && !m_we && !dest) mdr <= m_rdata;
`ifdef MEM_TIMEOUT_EN
      if (expired) bus_err <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: table-driven transactions with a completion scoreboard plus reset/ack corner cases
module tb_mem_port_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic in_reset, mem_read, mem_write, iord, ir_write, m_ack;
  logic [31:0] pc, alu_out, wdata, m_rdata;
  logic m_req, m_we, stall, bus_err;
  logic [31:0] m_addr, m_wdata, instr, mdr;
  mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .in_reset(in_reset), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .instr(instr), .mdr(mdr),
    .stall(stall), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic rd, wr, io, irw;
    logic [31:0] pc, alu, wd;
    int lat;
    logic [31:0] rdata, e_addr;
    logic e_we;
    int e_stall;
    logic [31:0] e_instr, e_mdr;
    logic e_err;
  } vec_t;
  typedef struct {
    logic [31:0] instr, mdr;
    logic err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  logic prev_req = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (prev_req && !m_req && !prev_rst && !in_reset) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: completion with empty scoreboard");
      end else begin
        mon_e = sb.pop_front();
        chk("done_instr", instr, mon_e.instr);
        chk("done_mdr", mdr, mon_e.mdr);
        chk("done_bus_err", bus_err, mon_e.err);
        chk("done_stall", stall, 0);
      end
    end
    prev_req = m_req;
    prev_rst = in_reset;
  end
  task automatic run_txn(input vec_t v);
    int sc = 0;
    bit done = 0;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; iord = v.io; ir_write = v.irw;
    pc = v.pc; alu_out = v.alu; wdata = v.wd;
    sb.push_back('{v.e_instr, v.e_mdr, v.e_err});
    for (int c = 0; c < 40 && !done; c++) begin
      m_ack = (c == v.lat);
      m_rdata = (c == v.lat) ? v.rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      if (c == 0) chk("stall_c0", stall, 1);
      if (c == 1) begin
        chk("req_c1", m_req, 1);
        chk("addr_c1", m_addr, v.e_addr);
        chk("we_c1", m_we, v.e_we);
        chk("wdata_c1", m_wdata, v.wd);
      end
      if (c > 1 && c == v.lat) begin
        chk("req_hold", m_req, 1);
        chk("addr_hold", m_addr, v.e_addr);
      end
      if (stall) sc++;
      else if (c > 0) done = 1;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL txn_hang: no DONE within 40 cycles");
    end
    chk("stall_cycles", sc, v.e_stall);
    chk("req_done", m_req, 0);
    m_ack = 1'b0;
  endtask
  task automatic go_idle();
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; m_ack = 0;
  endtask
  initial begin
    tbl[0] = '{1, 0, 0, 1, 32'h40, 32'h999, 32'h0, 3, 32'h2108_0005, 32'h40, 0, 4, 32'h2108_0005, 32'h0, 0};
    tbl[1] = '{1, 0, 1, 0, 32'h44, 32'h100, 32'h0, 1, 32'hCAFE_F00D, 32'h100, 0, 2, 32'h2108_0005, 32'hCAFE_F00D, 0};
    tbl[2] = '{1, 1, 1, 1, 32'h48, 32'h200, 32'h1234_5678, 2, 32'hDEAD_BEEF, 32'h200, 1, 3, 32'h2108_0005, 32'hCAFE_F00D, 0};
    tbl[3] = '{1, 0, 0, 1, 32'h44, 32'h300, 32'h0, 5, 32'h8C43_0004, 32'h44, 0, 6, 32'h8C43_0004, 32'hCAFE_F00D, 0};
    tbl[4] = '{0, 1, 1, 0, 32'h4C, 32'h204, 32'hA5A5_A5A5, 1, 32'h1111_1111, 32'h204, 1, 2, 32'h8C43_0004, 32'hCAFE_F00D, 0};
    tbl[5] = '{1, 0, 1, 0, 32'h50, 32'h104, 32'h0, 2, 32'h0000_0001, 32'h104, 0, 3, 32'h8C43_0004, 32'h0000_0001, 0};
    tbl[6] = '{1, 0, 1, 1, 32'h54, 32'h108, 32'h0, 1, 32'hFEED_FACE, 32'h108, 0, 2, 32'hFEED_FACE, 32'h0000_0001, 0};
    in_reset = 1; mem_read = 0; mem_write = 0; iord = 0; ir_write = 0;
    pc = 0; alu_out = 0; wdata = 0; m_ack = 0; m_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", m_req, 0);
    chk("rst_we", m_we, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_instr", instr, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    in_reset = 0;
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);
    go_idle();
    @(negedge clk);
    chk("idle_stall", stall, 0);
    @(posedge clk); #1;
    m_ack = 1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("spur_stall", stall, 0);
    @(posedge clk); #1;
    m_ack = 0;
    @(negedge clk);
    chk("spur_req", m_req, 0);
    chk("spur_instr", instr, 32'hFEED_FACE);
    chk("spur_mdr", mdr, 32'h0000_0001);
    @(posedge clk); #1;
    mem_read = 1; ir_write = 1; iord = 0; pc = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_reset = 1;
    @(negedge clk);
    chk("rst_busy_stall", stall, 0);
    @(posedge clk); #1;
    in_reset = 0; mem_read = 0; m_ack = 1; m_rdata = 32'h55;
    @(negedge clk);
    chk("rst_busy_req", m_req, 0);
    chk("rst_busy_instr", instr, 0);
    chk("rst_busy_mdr", mdr, 0);
    chk("rst_busy_idle", stall, 0);
    @(posedge clk); #1;
    m_ack = 0;
    @(negedge clk);
    chk("late_ack_instr", instr, 0);
    chk("late_ack_req", m_req, 0);
    run_txn('{1, 0, 1, 0, 32'h0, 32'h10, 32'h0, 1, 32'h77, 32'h10, 0, 2, 32'h0, 32'h77, 0});
`ifdef MEM_TIMEOUT_EN
    run_txn('{1, 0, 0, 1, 32'h60, 32'h0, 32'h0, 4, 32'hABCD_0001, 32'h60, 0, 5, 32'hABCD_0001, 32'h77, 0});
    run_txn('{1, 0, 1, 0, 32'h64, 32'h110, 32'h0, 99, 32'h0, 32'h110, 0, 5, 32'hABCD_0001, 32'h77, 1});
    run_txn('{1, 0, 1, 0, 32'h68, 32'h114, 32'h0, 1, 32'h88, 32'h114, 0, 2, 32'hABCD_0001, 32'h88, 1});
`else
    chk("no_timeout_err", bus_err, 0);
`endif
    go_idle();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
